// File: rtl/mem_periph_stage_if.sv
// mem_periph_stage_if -- memory-stage request/response bundle.
//
// Signals:
//   MEM_MemRead   load request (master -> slave)
//   MEM_MemWrite  store request (master -> slave)
//   MEM_ALUout    32-bit byte address, bits [1:0] ignored (master -> slave)
//   MEM_MUX1      32-bit store data (master -> slave)
//   MEM_ReadData  32-bit load data, combinational (slave -> master)
//
// Handshake: there is no valid/ready pair and no backpressure. MEM_MemRead
// and MEM_MemWrite qualify the address/data in the cycle they are high; the
// slave always accepts. A store commits on the next rising clk, a load
// returns data combinationally in the same cycle.
interface mem_periph_stage_if;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [31:0] MEM_ALUout;
  logic [31:0] MEM_MUX1;
  logic [31:0] MEM_ReadData;

  modport master (
    output MEM_MemRead,
    output MEM_MemWrite,
    output MEM_ALUout,
    output MEM_MUX1,
    input  MEM_ReadData
  );

  modport slave (
    input  MEM_MemRead,
    input  MEM_MemWrite,
    input  MEM_ALUout,
    input  MEM_MUX1,
    output MEM_ReadData
  );
endinterface

// File: rtl/mem_periph_stage.sv
// mem_periph_stage -- MEM pipeline stage: data memory plus memory-mapped
// timer, LED, seven-segment and optional SysTick peripherals.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   bus        mem_periph_stage_if.slave (load/store request, load data)
//   LED        8-bit LED register
//   Digi       12-bit seven-segment register (anode[11:8], segments[7:0])
//   Timer_IRQ  TCON[2] & TCON[1]
//
// Map: dmem 0 .. 4*DMEM_WORDS-1, TH 0x40000000, TL 0x40000004,
//      TCON 0x40000008, LED 0x4000000C, Digi 0x40000010,
//      SysTick 0x40000014 (read-only).
//
// Optional feature: define MEM_PERIPH_SYSTICK_EN to build the free-running
// SysTick counter; without it the SysTick address reads 0.
module mem_periph_stage #(
  parameter int DMEM_WORDS = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_periph_stage_if.slave        bus,
  output logic [7:0]               LED,
  output logic [11:0]              Digi,
  output logic                     Timer_IRQ
);
  localparam int AW = $clog2(DMEM_WORDS);

  // Word addresses (byte address >> 2) of the peripheral registers.
  localparam logic [29:0] W_TH      = 30'h1000_0000;
  localparam logic [29:0] W_TL      = 30'h1000_0001;
  localparam logic [29:0] W_TCON    = 30'h1000_0002;
  localparam logic [29:0] W_LED     = 30'h1000_0003;
  localparam logic [29:0] W_DIGI    = 30'h1000_0004;
  localparam logic [29:0] W_SYSTICK = 30'h1000_0005;

  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic        ovf;

  logic [29:0]   waddr;
  logic [AW-1:0] word_idx;
  logic          in_dmem;
  logic [31:0]   wdata;
  logic          wr_en;
  logic [31:0]   rdata;
  logic [31:0]   systick_rd;
  logic          unused_addr_lsbs;

  assign waddr            = bus.MEM_ALUout[31:2];
  assign word_idx         = bus.MEM_ALUout[AW+1:2];
  assign in_dmem          = (bus.MEM_ALUout[31:AW+2] == '0);
  assign wdata            = bus.MEM_MUX1;
  assign wr_en            = bus.MEM_MemWrite;
  assign unused_addr_lsbs = ^bus.MEM_ALUout[1:0];

`ifdef MEM_PERIPH_SYSTICK_EN
  logic [31:0] systick_q, systick_d;

  // Free-running; wraps naturally from all-ones to zero. Not CPU-writable.
  assign systick_d  = systick_q + 32'd1;
  assign systick_rd = systick_q;

  always_ff @(posedge clk) begin
    if (reset) systick_q <= '0;
    else       systick_q <= systick_d;
  end
`else
  assign systick_rd = '0;
`endif

  // Next-state: the timer advances first, then CPU writes override it;
  // an overflow in the same cycle still forces TCON[2] high.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    ovf    = 1'b0;
    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        ovf  = tcon_q[1];
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (wr_en && !in_dmem) begin
      case (waddr)
        W_TH:    th_d   = wdata;
        W_TL:    tl_d   = wdata;
        W_TCON:  tcon_d = wdata[2:0];
        W_LED:   led_d  = wdata[7:0];
        W_DIGI:  digi_d = wdata[11:0];
        default: ;
      endcase
    end
    if (ovf) tcon_d[2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
    end
  end

  // Data memory is never cleared; a store during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && in_dmem) dmem[word_idx] <= wdata;
  end

  // Read mux reflects pre-edge state, so a simultaneous load/store
  // returns the old word.
  always_comb begin
    rdata = '0;
    if (in_dmem) begin
      rdata = dmem[word_idx];
    end else begin
      case (waddr)
        W_TH:      rdata = th_q;
        W_TL:      rdata = tl_q;
        W_TCON:    rdata = {29'd0, tcon_q};
        W_LED:     rdata = {24'd0, led_q};
        W_DIGI:    rdata = {20'd0, digi_q};
        W_SYSTICK: rdata = systick_rd;
        default:   rdata = '0;
      endcase
    end
  end

  assign bus.MEM_ReadData = bus.MEM_MemRead ? rdata : 32'd0;
  assign LED              = led_q;
  assign Digi             = digi_q;
  assign Timer_IRQ        = tcon_q[2] & tcon_q[1];
endmodule

// File: tb/tb_mem_periph_stage.sv
// tb_mem_periph_stage -- directed plus randomized bench for mem_periph_stage
// against a behavioural model of the memory map.
module tb_mem_periph_stage;
  localparam int DMEM_WORDS = 256;
  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_ST   = 32'h4000_0014;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  LED;
  logic [11:0] Digi;
  logic        Timer_IRQ;

  always #5 clk = ~clk;

  mem_periph_stage_if bus ();

  mem_periph_stage #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .LED       (LED),
    .Digi      (Digi),
    .Timer_IRQ (Timer_IRQ)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_mem [int];
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [11:0] m_digi;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  function automatic logic [31:0] model_read(input logic rd, input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    if (!rd) return 32'd0;
    if (a < 4 * DMEM_WORDS) return m_mem.exists(int'(a >> 2)) ? m_mem[int'(a >> 2)] : 32'hx;
    case (a)
      A_TH:   return m_th;
      A_TL:   return m_tl;
      A_TCON: return {29'd0, m_tcon};
      A_LED:  return {24'd0, m_led};
      A_DIGI: return {20'd0, m_digi};
`ifdef MEM_PERIPH_SYSTICK_EN
      A_ST:   return m_systick;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge: timer first, then CPU store, overflow flag sticky.
  task automatic model_edge(input logic rst, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data);
    logic [31:0] a;
    logic [31:0] next_tl;
    bit          ovf;
    a = {addr[31:2], 2'b00};
    if (rst) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_systick = 0;
      return;
    end
    m_systick = m_systick + 1;
    ovf       = 0;
    next_tl   = m_tl;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        next_tl = m_th;
        ovf     = m_tcon[1];
      end else begin
        next_tl = m_tl + 1;
      end
    end
    m_tl = next_tl;
    if (wr) begin
      if (a < 4 * DMEM_WORDS) m_mem[int'(a >> 2)] = data;
      else begin
        case (a)
          A_TH:   m_th   = data;
          A_TL:   m_tl   = data;
          A_TCON: m_tcon = data[2:0];
          A_LED:  m_led  = data[7:0];
          A_DIGI: m_digi = data[11:0];
          default: ;
        endcase
      end
    end
    if (ovf) m_tcon[2] = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, check the combinational load before the
  // rising edge, then check registered outputs just after it.
  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data, input string tag);
    @(negedge clk);
    reset            = rst;
    bus.MEM_MemRead  = rd;
    bus.MEM_MemWrite = wr;
    bus.MEM_ALUout   = addr;
    bus.MEM_MUX1     = data;
    #1;
    exp_q.push_back(model_read(rd, addr));
    last_rd = bus.MEM_ReadData;
    chk({tag, "_rd"}, last_rd, exp_q.pop_front());
    @(posedge clk);
    model_edge(rst, wr, addr, data);
    #1;
    chk({tag, "_led"}, {24'd0, LED}, {24'd0, m_led});
    chk({tag, "_digi"}, {20'd0, Digi}, {20'd0, m_digi});
    chk({tag, "_irq"}, {31'd0, Timer_IRQ}, {31'd0, m_tcon[2] & m_tcon[1]});
  endtask

  task automatic wr_op(input logic [31:0] addr, input logic [31:0] data, input string tag);
    step(1'b0, 1'b0, 1'b1, addr, data, tag);
  endtask

  task automatic rd_op(input logic [31:0] addr, input string tag);
    step(1'b0, 1'b1, 1'b0, addr, 32'd0, tag);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset            = 1'b1;
    bus.MEM_MemRead  = 1'b0;
    bus.MEM_MemWrite = 1'b0;
    bus.MEM_ALUout   = '0;
    bus.MEM_MUX1     = '0;
    m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_systick = 0;

    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, "rst0");
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, "rst1");
    rd_op(A_TL, "rst_tl");     chk("reset_tl", last_rd, 32'd0);
    rd_op(A_TH, "rst_th");     chk("reset_th", last_rd, 32'd0);
    rd_op(A_TCON, "rst_tcon"); chk("reset_tcon", last_rd, 32'd0);
    chk("reset_led", {24'd0, LED}, 32'd0);

    // Store then load, and read-during-write ordering.
    wr_op(32'h10, 32'hDEAD_BEEF, "st10");
    rd_op(32'h10, "ld10");     chk("store_load", last_rd, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, "rw10");
    chk("rw_old_value", last_rd, 32'hDEAD_BEEF);
    rd_op(32'h10, "rw10n");    chk("rw_new_value", last_rd, 32'h1234_5678);
    wr_op(32'h10, 32'hDEAD_BEEF, "st10b");

    // Dmem boundary: last word and first address past the end.
    wr_op(32'h0, 32'hCAFE_0000, "st0");
    wr_op(32'h3FC, 32'hBBBB_0001, "st_last");
    wr_op(32'h400, 32'h5555_AAAA, "st_oob");
    rd_op(32'h3FC, "ld_last"); chk("dmem_last_word", last_rd, 32'hBBBB_0001);
    rd_op(32'h400, "ld_oob");  chk("dmem_out_of_range", last_rd, 32'd0);
    rd_op(32'h0, "ld0");       chk("dmem_no_alias", last_rd, 32'hCAFE_0000);
    step(1'b0, 1'b0, 1'b0, A_TH, 32'd0, "noread");
    chk("memread_low", last_rd, 32'd0);

    // Timer reload and interrupt.
    wr_op(A_TH, 32'hFFFF_FFF0, "th");
    wr_op(A_TL, 32'hFFFF_FFFE, "tl");
    wr_op(A_TCON, 32'd3, "tcon3");
    rd_op(A_TL, "t0");         chk("timer_start", last_rd, 32'hFFFF_FFFE);
    rd_op(A_TL, "t1");         chk("timer_1cyc", last_rd, 32'hFFFF_FFFF);
    chk("timer_irq", {31'd0, Timer_IRQ}, 32'd1);
    rd_op(A_TL, "t2");         chk("timer_reload", last_rd, 32'hFFFF_FFF0);
    wr_op(A_TCON, 32'd0, "tcon0");
    chk("irq_cleared", {31'd0, Timer_IRQ}, 32'd0);

    // Overflow beats a same-cycle TCON write of bit 2 = 0.
    wr_op(A_TL, 32'hFFFF_FFFD, "tl_fd");
    wr_op(A_TCON, 32'd3, "tcon3b");
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "idle_a");
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "idle_b");
    wr_op(A_TCON, 32'd3, "tcon_ovf");
    rd_op(A_TCON, "rd_tcon");  chk("ovf_wins", last_rd, 32'd7);

    // CPU write to TL beats the increment.
    wr_op(A_TCON, 32'd1, "tcon1");
    wr_op(A_TL, 32'h0000_0100, "tl_prio");
    rd_op(A_TL, "rd_tl_prio"); chk("tl_write_prio", last_rd, 32'h0000_0100);
    wr_op(A_TCON, 32'd0, "tcon0b");

    // LED and Digi, then reset with a coincident store.
    wr_op(A_LED, 32'hFFFF_FFA5, "led");
    chk("led_a5", {24'd0, LED}, 32'h0000_00A5);
    wr_op(A_DIGI, 32'hFFFF_F3C7, "digi");
    chk("digi_val", {20'd0, Digi}, 32'h0000_03C7);
    step(1'b1, 1'b0, 1'b1, 32'h10, 32'h1111_1111, "rst_st");
    chk("led_after_reset", {24'd0, LED}, 32'd0);
    step(1'b1, 1'b0, 1'b1, A_LED, 32'hFF, "rst_led");
    chk("led_store_in_reset", {24'd0, LED}, 32'd0);
    rd_op(32'h10, "ld_after_rst"); chk("dmem_survives_reset", last_rd, 32'hDEAD_BEEF);

    // Unmapped and read-only addresses.
    rd_op(32'h4000_0020, "unmapped"); chk("unmapped_read", last_rd, 32'd0);
    wr_op(A_ST, 32'h7777_7777, "st_systick");
    rd_op(A_ST, "rd_systick");
`ifndef MEM_PERIPH_SYSTICK_EN
    chk("systick_absent", last_rd, 32'd0);
`endif

    // Random phase: dmem words 0..15 initialised first.
    for (int w = 0; w < 16; w++) wr_op(32'(w * 4), $urandom, "init");
    for (int i = 0; i < 400; i++) begin
      int          sel;
      logic [31:0] a;
      logic [31:0] d;
      logic        rd;
      logic        wr;
      logic        rst;
      sel = $urandom_range(0, 11);
      d   = $urandom;
      if (sel <= 4) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else if (sel <= 10) a = A_TH + 32'((sel - 5) * 4);
      else begin
        case ($urandom_range(0, 3))
          0:       a = 32'h4000_0020;
          1:       a = 32'h8000_0000;
          2:       a = 32'h0000_0400;
          default: a = 32'h4000_0018;
        endcase
      end
      if (a == A_TL && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      rd  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 59) == 0);
      step(rst, rd, wr, a, d, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_periph_stage.md
MEM_PERIPH_STAGE -- requirements
Module: mem_periph_stage

Interface
REQ-001 Parameter DMEM_WORDS, default 256: data-memory depth in 32-bit words (power of two).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 MEM_MemRead  input  1  load request from the EX/MEM register.
REQ-005 MEM_MemWrite  input  1  store request from the EX/MEM register.
REQ-006 MEM_ALUout  input  32  byte address; bits [1:0] ignored.
REQ-007 MEM_MUX1  input  32  store data.
REQ-008 MEM_ReadData  output  32  load data, combinational from the current address.
REQ-009 LED  output  8  LED register.
REQ-010 Digi  output  12  seven-segment register (anode[11:8], segments[7:0]).
REQ-011 Timer_IRQ  output  1  equals TCON[2] AND TCON[1].

Function
REQ-012 Address 0x00000000 to 4*DMEM_WORDS-1 SHALL select data memory, indexed by MEM_ALUout[log2(DMEM_WORDS)+1:2].
REQ-013 Peripheral map SHALL be: TH 0x40000000, TL 0x40000004, TCON[2:0] 0x40000008, LED 0x4000000C, Digi 0x40000010, SysTick 0x40000014 (read-only).
REQ-014 A store SHALL commit on the rising edge where MEM_MemWrite=1; a load SHALL present data in the same cycle (zero added latency).
REQ-015 MEM_ReadData SHALL be 0 when MEM_MemRead=0 or the address is unmapped; writes to unmapped or read-only addresses SHALL be ignored.
REQ-016 With MemRead and MemWrite both 1, MEM_ReadData SHALL show the pre-write value; the new value SHALL be visible from the next cycle.
REQ-017 Timer, while TCON[0]=1: TL SHALL increment by 1 per cycle; when TL=0xFFFFFFFF it SHALL reload TH instead, and TCON[2] SHALL set if TCON[1]=1.
REQ-018 A CPU write to TL or TH SHALL take priority over a same-cycle timer increment or reload.
REQ-019 A CPU write to TCON SHALL set bits [1:0] from data; bit 2 SHALL take the written value except when a same-cycle overflow sets it, in which case it SHALL read 1.
REQ-020 Unused peripheral bits SHALL read 0; sub-word accesses are not supported.

Reset
REQ-021 On reset: TH, TL, TCON, LED, Digi and SysTick SHALL be 0; Timer_IRQ SHALL be 0.
REQ-022 Data-memory contents SHALL NOT be cleared by reset.
REQ-023 A store coincident with reset SHALL be discarded for peripherals and SHALL NOT commit to data memory.

Configuration
REQ-024 Macro MEM_PERIPH_SYSTICK_EN defined: SysTick SHALL be a free-running 32-bit counter, +1 per cycle, wrapping from 0xFFFFFFFF to 0.
REQ-025 Macro undefined: no SysTick register SHALL exist; reads of 0x40000014 SHALL return 0.

Verification
REQ-026 Store 0xDEADBEEF to 0x00000010, then load 0x00000010 -> ReadData=0xDEADBEEF in the load cycle.
REQ-027 TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3 -> TL=0xFFFFFFFF after 1 cycle, TL=0xFFFFFFF0 and Timer_IRQ=1 after 2 cycles.
REQ-028 TCON=3 with TL=0xFFFFFFFF while writing TCON=3 -> TCON reads 7 next cycle (overflow set wins).
REQ-029 Write LED=0xA5, then assert reset for 1 cycle -> LED=0, and dmem word 4 still returns 0xDEADBEEF.
REQ-030 Load 0x40000020 -> ReadData=0; store to 0x40000014 -> SysTick unchanged (with macro: +1 per cycle only; without: reads 0).
